decoder_256_pipe: RTL and testbench

DECODER_256_PIPE -- requirements
Module: decoder_256_pipe

---
 rtl/decoder_256_pipe.sv | 111 +++++++++++
 tb/tb_decoder_256_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_256_pipe.sv
// 8-to-256 one-hot decoder with a registered valid/ready output stage
// and a self-sweep scan mode that emits every index 0..255 in order.
module decoder_256_pipe #(
  parameter int SCAN_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   code,
  input  logic         code_valid,
  output logic         code_ready,
  input  logic         scan_start,
  output logic [255:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         scan_done
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [255:0] out_q, out_d;
  logic         out_valid_q, out_valid_d;
  logic         last_q, last_d;
  logic         done_q, done_d;

  logic scan_go;
  logic in_xfer;
  logic out_xfer;

  assign scan_go  = scan_start && (SCAN_EN != 0);
  assign out_xfer = out_valid_q && out_ready;
  assign in_xfer  = code_valid && code_ready;

  assign code_ready = (state_q == IDLE) && !scan_go
                   && (!out_valid_q || out_ready);

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == SCAN);
  assign scan_done = done_q;

  // Next-state: drain/refill the output register and sequence the scan.
  // last_q marks that index 255 is already loaded, so the wrapped
  // counter never launches a second sweep.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    done_d      = 1'b0;

    if (out_xfer) begin
      out_d       = '0;
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (scan_go) begin
          state_d = SCAN;
          cnt_d   = 8'd0;
          last_d  = 1'b0;
        end else if (in_xfer) begin
          out_d       = 256'd1 << code;
          out_valid_d = 1'b1;
        end
      end
      SCAN: begin
        if (last_q) begin
          if (out_xfer) begin
            state_d = IDLE;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else if (!out_valid_q || out_xfer) begin
          out_d       = 256'd1 << cnt_q;
          out_valid_d = 1'b1;
          cnt_d       = cnt_q + 8'd1;
          last_d      = (cnt_q == 8'hFF);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_decoder_256_pipe.sv
// Bench for decoder_256_pipe: directed vector table, random
// decode traffic and scan sweeps against a queue-based model.
module tb_decoder_256_pipe;

  logic         clk;
  logic         rst;
  logic [7:0]   code;
  logic         code_valid;
  logic         code_ready;
  logic         scan_start;
  logic [255:0] out;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         scan_done;

  int checks;
  int failures;

  decoder_256_pipe #(.SCAN_EN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .scan_start (scan_start),
    .out        (out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .scan_done  (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       cv;
    logic       ordy;
    logic       ov;
    logic [7:0] idx;
    logic       cr;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [255:0] bit_of(input int idx);
    logic [255:0] one;
    one = 256'd1;
    return one << idx;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_onehot();
    logic ok_b;
    ok_b = out_valid ? $onehot(out) : (out == '0);
    chk("onehot", {255'd0, ok_b}, 256'd1);
  endtask

  task automatic run_scan(input bit rnd, input int pend);
    int  q[$];
    int  cyc, first, last, n0;
    bit  prev_last;
    if (pend >= 0) begin
      code       = 8'(pend);
      code_valid = 1'b1;
      out_ready  = 1'b0;
      step();
      code_valid = 1'b0;
      q.push_back(pend);
    end
    for (int i = 0; i < 256; i++) q.push_back(i);
    n0 = q.size();
    scan_start = 1'b1;
    code_valid = 1'b1;
    code       = 8'hAA;
    out_ready  = 1'b0;
    @(negedge clk);
    chk("start_cr", {255'd0, code_ready}, 256'd0);
    step();
    scan_start = 1'b0;
    code_valid = 1'b0;
    cyc = 0;
    prev_last = 1'b0;
    first = -1;
    last = -1;
    while ((q.size() > 0 || prev_last) && cyc < 3000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd && q.size() > 0) begin
        scan_start = ($urandom_range(0, 7) == 0);
        code_valid = 1'($urandom_range(0, 1));
        code       = 8'($urandom);
      end
      @(negedge clk);
      chk("scan_done", {255'd0, scan_done}, {255'd0, prev_last});
      if (q.size() > 0) begin
        chk("scan_busy", {255'd0, busy}, 256'd1);
        chk("scan_cr", {255'd0, code_ready}, 256'd0);
      end
      chk_onehot();
      prev_last = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra_word", {255'd0, out_valid}, 256'd0);
        end else begin
          chk("scan_word", out, bit_of(q[0]));
          if (first < 0) first = cyc;
          last = cyc;
          if (q.size() == 1) prev_last = 1'b1;
          void'(q.pop_front());
        end
      end
      cyc++;
      step();
      scan_start = 1'b0;
      code_valid = 1'b0;
    end
    if (cyc >= 3000) begin
      checks++;
      failures++;
      $display("FAIL scan_timeout words_left=%0d", q.size());
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_done", {255'd0, scan_done}, 256'd0);
    chk("post_busy", {255'd0, busy}, 256'd0);
    chk("post_ov", {255'd0, out_valid}, 256'd0);
    chk("post_cr", {255'd0, code_ready}, 256'd1);
    if (!rnd) chk("scan_span", 256'(last - first), 256'(n0 - 1));
    step();
  endtask

  initial begin
    int  mq[$];
    bit  exp_cr;
    bit  found;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    code       = 8'h00;
    code_valid = 1'b0;
    scan_start = 1'b0;
    out_ready  = 1'b0;

    tbl[0] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'd0,   1'b1};
    tbl[1] = '{8'h7F, 1'b1, 1'b1, 1'b1, 8'd0,   1'b1};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'd127, 1'b1};
    tbl[3] = '{8'h05, 1'b1, 1'b1, 1'b1, 8'd255, 1'b1};
    tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'd5,   1'b0};
    tbl[5] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'd5,   1'b0};
    tbl[6] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'd5,   1'b0};
    tbl[7] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'd5,   1'b0};
    tbl[8] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'd5,   1'b1};
    tbl[9] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'd0,   1'b1};

    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out", out, 256'd0);
    chk("rst_ov", {255'd0, out_valid}, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_done", {255'd0, scan_done}, 256'd0);
    chk("rst_cr", {255'd0, code_ready}, 256'd1);
    step();

    for (int i = 0; i < 10; i++) begin
      code       = tbl[i].code;
      code_valid = tbl[i].cv;
      out_ready  = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_out", i), out,
          tbl[i].ov ? bit_of(int'(tbl[i].idx)) : 256'd0);
      chk($sformatf("vec%0d_ov", i), {255'd0, out_valid},
          {255'd0, tbl[i].ov});
      chk($sformatf("vec%0d_cr", i), {255'd0, code_ready},
          {255'd0, tbl[i].cr});
      step();
    end

    for (int i = 0; i < 200; i++) begin
      code       = 8'($urandom);
      code_valid = 1'($urandom_range(0, 1));
      out_ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_cr = (mq.size() == 0) || out_ready;
      chk("rnd_cr", {255'd0, code_ready}, {255'd0, exp_cr});
      chk("rnd_ov", {255'd0, out_valid}, {255'd0, mq.size() != 0});
      if (mq.size() != 0) chk("rnd_out", out, bit_of(mq[0]));
      else chk("rnd_zero", out, 256'd0);
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (code_valid && exp_cr) mq.push_back(int'(code));
      step();
    end
    code_valid = 1'b0;
    out_ready  = 1'b1;
    step();

    run_scan(1'b0, -1);
    run_scan(1'b1, 8'h42);

    scan_start = 1'b1;
    out_ready  = 1'b0;
    step();
    scan_start = 1'b0;
    out_ready  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out == bit_of(100)) found = 1'b1;
      step();
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL abort_timeout index 100 never seen");
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ov", {255'd0, out_valid}, 256'd0);
    chk("abort_busy", {255'd0, busy}, 256'd0);
    chk("abort_done", {255'd0, scan_done}, 256'd0);
    chk("abort_cr", {255'd0, code_ready}, 256'd1);
    code       = 8'h03;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    out_ready  = 1'b0;
    @(negedge clk);
    chk("abort_new_out", out, bit_of(3));
    chk("abort_new_ov", {255'd0, out_valid}, 256'd1);
    chk("abort_no_done", {255'd0, scan_done}, 256'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
